spi_reg_slave: RTL and testbench

- Parametrised SPI slave register-file model for the integration benches; successor to the fixed 8-bit, mode-0, single-byte MFRC522 model.
- Supports configurable address/data width, all four SPI modes (CPOL/CPHA), and multi-word burst frames with address auto-increment.
- Adds a host-side backdoor port and a frame-completion pulse.
- Sits on the SPI pins of the spi_axi master under test; oversamples SCK with the system clock.

---
 rtl/spi_reg_slave.sv | 223 ++++++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave.sv
`default_nettype none
//==============================================================================
// Module   : spi_reg_slave
// Purpose  : SPI slave register file with selectable CPOL/CPHA and burst access.
// Revision : 1.0  initial parametrised release
//==============================================================================
module spi_reg_slave #(
   parameter int                ADDR_W   = 7,
   parameter int                DATA_W   = 8,
   parameter int                CPOL     = 0,
   parameter int                CPHA     = 0,
   parameter int                AUTO_INC = 1,
   parameter logic [ADDR_W-1:0] ID_ADDR  = 7'h37,
   parameter logic [DATA_W-1:0] ID_VAL   = 8'h91
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs_n,
   input  logic              sck,
   input  logic              mosi,
   output wire               miso,
   output logic              miso_oe,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic [DATA_W-1:0] host_rdata,
   output logic              frame_done,
   output logic [7:0]        word_count,
   output logic [ADDR_W-1:0] last_addr,
   output logic [DATA_W-1:0] last_data,
   output logic              last_rw
);

   localparam int C_CMD_W = 1 + ADDR_W;
   localparam int C_RX_W  = (C_CMD_W > DATA_W) ? C_CMD_W : DATA_W;
   localparam int C_CNT_W = $clog2(C_RX_W + 1);
   localparam int C_DEPTH = 2 ** ADDR_W;
   localparam logic C_POL = (CPOL != 0);

   localparam logic [C_CNT_W-1:0] C_CMD_LAST  = C_CNT_W'(C_CMD_W - 1);
   localparam logic [C_CNT_W-1:0] C_DATA_LAST = C_CNT_W'(DATA_W - 1);

   localparam logic [1:0] C_IDLE = 2'd0;
   localparam logic [1:0] C_CMD  = 2'd1;
   localparam logic [1:0] C_WR   = 2'd2;
   localparam logic [1:0] C_RD   = 2'd3;

   logic [1:0]          r_cs_s, r_sck_s, r_mosi_s;
   logic                r_cs_prev, r_sck_prev;
   logic [1:0]          r_state;
   logic [C_CNT_W-1:0]  r_bitcnt;
   logic [C_RX_W-2:0]   r_rx;
   logic [DATA_W-1:0]   r_tx;
   logic [DATA_W-1:0]   r_rd_word;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_load;
   logic                r_miso_oe;
   logic                r_frame_done;
   logic [7:0]          r_word_count;
   logic [ADDR_W-1:0]   r_last_addr;
   logic [DATA_W-1:0]   r_last_data;
   logic                r_last_rw;
   logic [DATA_W-1:0]   r_mem [C_DEPTH];

   logic                w_cs, w_sck, w_mosi;
   logic                w_lead, w_trail, w_sample, w_shift, w_cs_fall;
   logic [C_CMD_W-1:0]  w_cmd;
   logic [DATA_W-1:0]   w_word;
   logic [ADDR_W-1:0]   w_next_addr;
   logic [7:0]          w_wc_inc;
   logic                w_spi_we;

   assign w_cs   = r_cs_s[1];
   assign w_sck  = r_sck_s[1];
   assign w_mosi = r_mosi_s[1];

   // Leading edge leaves the idle level, trailing edge returns to it.
   assign w_lead    = (w_sck != C_POL) && (r_sck_prev == C_POL);
   assign w_trail   = (w_sck == C_POL) && (r_sck_prev != C_POL);
   assign w_sample  = (CPHA != 0) ? w_trail : w_lead;
   assign w_shift   = (CPHA != 0) ? w_lead  : w_trail;
   assign w_cs_fall = !w_cs && r_cs_prev;

   assign w_cmd       = {r_rx[C_CMD_W-2:0], w_mosi};
   assign w_word      = {r_rx[DATA_W-2:0], w_mosi};
   assign w_next_addr = (AUTO_INC != 0) ? r_addr + ADDR_W'(1) : r_addr;
   assign w_wc_inc    = (r_word_count == 8'hFF) ? r_word_count : r_word_count + 8'd1;
   assign w_spi_we    = (r_state == C_WR) && w_sample && !w_cs &&
                        (r_bitcnt == C_DATA_LAST) && (r_addr != ID_ADDR);

   // SPI write is applied after the backdoor so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < C_DEPTH; i++) begin
            r_mem[i] <= (ADDR_W'(i) == ID_ADDR) ? ID_VAL : '0;
         end
      end else begin
         if (host_we && (host_addr != ID_ADDR)) begin
            r_mem[host_addr] <= host_wdata;
         end
         if (w_spi_we) begin
            r_mem[r_addr] <= w_word;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cs_s       <= 2'b00;
         r_sck_s      <= {C_POL, C_POL};
         r_mosi_s     <= 2'b00;
         r_cs_prev    <= 1'b0;
         r_sck_prev   <= C_POL;
         r_state      <= C_IDLE;
         r_bitcnt     <= '0;
         r_rx         <= '0;
         r_tx         <= '0;
         r_rd_word    <= '0;
         r_addr       <= '0;
         r_load       <= 1'b0;
         r_miso_oe    <= 1'b0;
         r_frame_done <= 1'b0;
         r_word_count <= 8'd0;
         r_last_addr  <= '0;
         r_last_data  <= '0;
         r_last_rw    <= 1'b0;
      end else begin
         r_cs_s       <= {r_cs_s[0], cs_n};
         r_sck_s      <= {r_sck_s[0], sck};
         r_mosi_s     <= {r_mosi_s[0], mosi};
         r_cs_prev    <= w_cs;
         r_sck_prev   <= w_sck;
         r_frame_done <= 1'b0;
         r_load       <= 1'b0;

         if (r_load) begin
            r_tx      <= r_mem[r_addr];
            r_rd_word <= r_mem[r_addr];
            r_miso_oe <= 1'b1;
         end

         if ((r_state != C_IDLE) && w_cs) begin
            r_state      <= C_IDLE;
            r_bitcnt     <= '0;
            r_miso_oe    <= 1'b0;
            r_frame_done <= (r_word_count != 8'd0);
         end else begin
            case (r_state)
               C_IDLE: begin
                  if (w_cs_fall) begin
                     r_state      <= C_CMD;
                     r_bitcnt     <= '0;
                     r_word_count <= 8'd0;
                  end
               end
               C_CMD: begin
                  if (w_sample) begin
                     if (r_bitcnt == C_CMD_LAST) begin
                        r_addr   <= w_cmd[ADDR_W-1:0];
                        r_bitcnt <= '0;
                        if (w_cmd[C_CMD_W-1]) begin
                           r_state <= C_RD;
                           r_load  <= 1'b1;
                        end else begin
                           r_state <= C_WR;
                        end
                     end else begin
                        r_rx     <= {r_rx[C_RX_W-3:0], w_mosi};
                        r_bitcnt <= r_bitcnt + C_CNT_W'(1);
                     end
                  end
               end
               C_WR: begin
                  if (w_sample) begin
                     if (r_bitcnt == C_DATA_LAST) begin
                        r_last_addr  <= r_addr;
                        r_last_data  <= w_word;
                        r_last_rw    <= 1'b0;
                        r_word_count <= w_wc_inc;
                        r_addr       <= w_next_addr;
                        r_bitcnt     <= '0;
                     end else begin
                        r_rx     <= {r_rx[C_RX_W-3:0], w_mosi};
                        r_bitcnt <= r_bitcnt + C_CNT_W'(1);
                     end
                  end
               end
               C_RD: begin
                  // The MSB of a freshly loaded word must survive until it is sampled.
                  if (w_shift && (r_bitcnt != '0)) begin
                     r_tx <= {r_tx[DATA_W-2:0], 1'b0};
                  end
                  if (w_sample) begin
                     if (r_bitcnt == C_DATA_LAST) begin
                        r_last_addr  <= r_addr;
                        r_last_data  <= r_rd_word;
                        r_last_rw    <= 1'b1;
                        r_word_count <= w_wc_inc;
                        r_addr       <= w_next_addr;
                        r_bitcnt     <= '0;
                        r_load       <= 1'b1;
                     end else begin
                        r_bitcnt <= r_bitcnt + C_CNT_W'(1);
                     end
                  end
               end
               default: r_state <= C_IDLE;
            endcase
         end
      end
   end

   assign miso       = (r_miso_oe && !cs_n) ? r_tx[DATA_W-1] : 1'bz;
   assign miso_oe    = r_miso_oe;
   assign host_rdata = r_mem[host_addr];
   assign frame_done = r_frame_done;
   assign word_count = r_word_count;
   assign last_addr  = r_last_addr;
   assign last_data  = r_last_data;
   assign last_rw    = r_last_rw;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
`default_nettype none
//==============================================================================
// Module   : tb_spi_reg_slave
// Purpose  : Directed bench for three spi_reg_slave configurations with a memory model.
// Revision : 1.0
//==============================================================================
module tb_spi_reg_slave;

   localparam int HALF = 80;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  cs_n_v = 3'b111;
   logic [2:0]  sck_v  = 3'b010;
   logic [2:0]  mosi_v = 3'b000;
   logic [2:0]  host_we_v = 3'b000;
   logic [2:0]  host_sel  = 3'b000;
   logic [2:0]  chk_en    = 3'b000;
   logic [6:0]  stim_addr = 7'd0;
   logic [15:0] stim_wdata = 16'd0;
   logic [6:0]  scan = 7'd0;

   wire        miso0, miso1, miso2;
   wire [2:0]  oe_v, fd_v, lr_v;
   wire [7:0]  rd0, rd1, wc0, wc1, wc2, ld0, ld1;
   wire [15:0] rd2, ld2;
   wire [6:0]  la0, la1;
   wire [5:0]  la2;
   wire [6:0]  ha0 = host_sel[0] ? stim_addr : scan;
   wire [6:0]  ha1 = host_sel[1] ? stim_addr : scan;
   wire [5:0]  ha2 = host_sel[2] ? stim_addr[5:0] : scan[5:0];

   always #5 clk = ~clk;
   always @(posedge clk) scan <= scan + 7'd1;

   spi_reg_slave u_m0 (
      .clk(clk), .rst(rst), .cs_n(cs_n_v[0]), .sck(sck_v[0]), .mosi(mosi_v[0]),
      .miso(miso0), .miso_oe(oe_v[0]), .host_we(host_we_v[0]), .host_addr(ha0),
      .host_wdata(stim_wdata[7:0]), .host_rdata(rd0), .frame_done(fd_v[0]),
      .word_count(wc0), .last_addr(la0), .last_data(ld0), .last_rw(lr_v[0]));

   spi_reg_slave #(.CPOL(1), .CPHA(1)) u_m3 (
      .clk(clk), .rst(rst), .cs_n(cs_n_v[1]), .sck(sck_v[1]), .mosi(mosi_v[1]),
      .miso(miso1), .miso_oe(oe_v[1]), .host_we(host_we_v[1]), .host_addr(ha1),
      .host_wdata(stim_wdata[7:0]), .host_rdata(rd1), .frame_done(fd_v[1]),
      .word_count(wc1), .last_addr(la1), .last_data(ld1), .last_rw(lr_v[1]));

   spi_reg_slave #(.ADDR_W(6), .DATA_W(16), .AUTO_INC(0), .ID_ADDR(6'h2A),
                   .ID_VAL(16'hC0DE)) u_w16 (
      .clk(clk), .rst(rst), .cs_n(cs_n_v[2]), .sck(sck_v[2]), .mosi(mosi_v[2]),
      .miso(miso2), .miso_oe(oe_v[2]), .host_we(host_we_v[2]), .host_addr(ha2),
      .host_wdata(stim_wdata), .host_rdata(rd2), .frame_done(fd_v[2]),
      .word_count(wc2), .last_addr(la2), .last_data(ld2), .last_rw(lr_v[2]));

   int          checks = 0;
   int          failures = 0;
   int          fd_cnt [3] = '{0, 0, 0};
   logic [15:0] mdl [3][128];
   int          exp_la [3] = '{0, 0, 0};
   int          exp_ld [3] = '{0, 0, 0};
   int          exp_lr [3] = '{0, 0, 0};

   always @(posedge clk) begin
      if (fd_v[0]) fd_cnt[0] <= fd_cnt[0] + 1;
      if (fd_v[1]) fd_cnt[1] <= fd_cnt[1] + 1;
      if (fd_v[2]) fd_cnt[2] <= fd_cnt[2] + 1;
   end

   function automatic int aw(input int d);      return (d == 2) ? 6 : 7;        endfunction
   function automatic int dw(input int d);      return (d == 2) ? 16 : 8;       endfunction
   function automatic int idaddr(input int d);  return (d == 2) ? 'h2A : 'h37;  endfunction
   function automatic bit autoinc(input int d); return d != 2;                  endfunction
   function automatic logic cpol(input int d);  return d == 1;                  endfunction
   function automatic logic cpha(input int d);  return d == 1;                  endfunction

   function automatic logic [15:0] rdata(input int d);
      case (d)
         0:       return {8'h00, rd0};
         1:       return {8'h00, rd1};
         default: return rd2;
      endcase
   endfunction
   function automatic int haddr(input int d);
      case (d)
         0:       return int'(ha0);
         1:       return int'(ha1);
         default: return int'(ha2);
      endcase
   endfunction
   function automatic logic miso_of(input int d);
      case (d)
         0:       return miso0;
         1:       return miso1;
         default: return miso2;
      endcase
   endfunction
   function automatic logic [31:0] wc_of(input int d);
      case (d)
         0:       return 32'(wc0);
         1:       return 32'(wc1);
         default: return 32'(wc2);
      endcase
   endfunction
   function automatic logic [31:0] la_of(input int d);
      case (d)
         0:       return 32'(la0);
         1:       return 32'(la1);
         default: return 32'(la2);
      endcase
   endfunction
   function automatic logic [31:0] ld_of(input int d);
      case (d)
         0:       return 32'(ld0);
         1:       return 32'(ld1);
         default: return 32'(ld2);
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Idle-time scan: register file must match the model and MISO stays released.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (chk_en[d]) begin
            check($sformatf("scan_rdata_d%0d_a%0h", d, haddr(d)), 32'(rdata(d)),
                  32'(mdl[d][haddr(d)]));
            check($sformatf("idle_miso_oe_d%0d", d), 32'(oe_v[d]), 32'd0);
         end
      end
   end

   task automatic spi_frame(input int d, input logic [63:0] bits, input int n,
                            output logic [63:0] rx);
      logic pol, pha;
      pol = cpol(d);
      pha = cpha(d);
      rx  = '0;
      cs_n_v[d] = 1'b0;
      if (!pha) mosi_v[d] = bits[n-1];
      #(HALF);
      for (int i = n - 1; i >= 0; i--) begin
         if (pha) begin
            sck_v[d] = ~pol;
            mosi_v[d] = bits[i];
            #(HALF);
            sck_v[d] = pol;
            rx[i] = miso_of(d);
            #(HALF);
         end else begin
            sck_v[d] = ~pol;
            rx[i] = miso_of(d);
            #(HALF);
            sck_v[d] = pol;
            if (i > 0) mosi_v[d] = bits[i-1];
            #(HALF);
         end
      end
      cs_n_v[d] = 1'b1;
      mosi_v[d] = 1'b0;
      repeat (10) @(posedge clk);
   endtask

   // Sends cmd + nw data words + 'extra' partial bits, then checks against the model.
   task automatic run_frame(input int d, input bit rw, input int addr,
                            input logic [3:0][15:0] wd, input int nw, input int extra,
                            output logic [3:0][15:0] got);
      int          a_w, d_w, c_w, n, a, fd0;
      logic [63:0] bits, rx, mask, w;
      a_w  = aw(d);
      d_w  = dw(d);
      c_w  = 1 + a_w;
      n    = c_w + nw * d_w + extra;
      mask = (64'd1 << d_w) - 64'd1;
      bits = (64'(rw) << a_w) | 64'(addr);
      for (int k = 0; k < nw; k++) bits = (bits << d_w) | (rw ? 64'd0 : 64'(wd[k]));
      bits = (bits << extra) | ((64'd1 << extra) - 64'd1);
      got  = '0;
      chk_en[d] = 1'b0;
      fd0 = fd_cnt[d];
      @(negedge clk);
      spi_frame(d, bits, n, rx);
      a = addr;
      for (int k = 0; k < nw; k++) begin
         w = (rx >> (n - c_w - (k + 1) * d_w)) & mask;
         got[k] = w[15:0];
         if (rw) begin
            check($sformatf("rd_word_d%0d_a%0h", d, a), w[31:0], 32'(mdl[d][a]));
            exp_ld[d] = int'(mdl[d][a]);
         end else begin
            exp_ld[d] = int'(wd[k]);
            if (a != idaddr(d)) mdl[d][a] = wd[k];
         end
         exp_la[d] = a;
         exp_lr[d] = int'(rw);
         if (autoinc(d)) a = (a + 1) % (1 << a_w);
      end
      check($sformatf("word_count_d%0d", d), wc_of(d), 32'((nw > 255) ? 255 : nw));
      check($sformatf("last_addr_d%0d", d), la_of(d), 32'(exp_la[d]));
      check($sformatf("last_data_d%0d", d), ld_of(d), 32'(exp_ld[d]));
      check($sformatf("last_rw_d%0d", d), 32'(lr_v[d]), 32'(exp_lr[d]));
      check($sformatf("frame_done_pulses_d%0d", d), 32'(fd_cnt[d] - fd0),
            32'((nw > 0) ? 1 : 0));
      chk_en[d] = 1'b1;
   endtask

   task automatic poke(input int d, input int addr, input logic [15:0] data);
      chk_en[d] = 1'b0;
      @(posedge clk); #1;
      host_sel[d]  = 1'b1;
      stim_addr    = 7'(addr);
      stim_wdata   = data;
      host_we_v[d] = 1'b1;
      @(posedge clk); #1;
      host_we_v[d] = 1'b0;
      host_sel[d]  = 1'b0;
      if (addr != idaddr(d)) mdl[d][addr] = data;
      chk_en[d] = 1'b1;
   endtask

   task automatic peek(input int d, input int addr, input logic [15:0] exp, input string name);
      chk_en[d] = 1'b0;
      @(posedge clk); #1;
      host_sel[d] = 1'b1;
      stim_addr   = 7'(addr);
      @(negedge clk);
      check(name, 32'(rdata(d)), 32'(exp));
      @(posedge clk); #1;
      host_sel[d] = 1'b0;
      chk_en[d]   = 1'b1;
   endtask

   initial begin
      #(5ms);
      $display("FAIL watchdog: simulation did not finish, time %0t limit 5ms", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0][15:0] got;
      for (int d = 0; d < 3; d++) begin
         for (int a = 0; a < 128; a++) mdl[d][a] = 16'h0;
      end
      mdl[0]['h37] = 16'h91;
      mdl[1]['h37] = 16'h91;
      mdl[2]['h2A] = 16'hC0DE;

      repeat (4) @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
         check("reset_word_count", wc_of(d), 32'd0);
         check("reset_last_addr", la_of(d), 32'd0);
         check("reset_last_data", ld_of(d), 32'd0);
         check("reset_last_rw", 32'(lr_v[d]), 32'd0);
         check("reset_miso_oe", 32'(oe_v[d]), 32'd0);
         check("reset_frame_done", 32'(fd_cnt[d]), 32'd0);
      end
      chk_en = 3'b111;
      peek(0, 'h37, 16'h91, "reset_id_m0");
      peek(2, 'h2A, 16'hC0DE, "reset_id_w16");

      // Mode 0: identification read
      run_frame(0, 1'b1, 'h37, '0, 1, 0, got);
      check("id_read_value", 32'(got[0]), 32'h91);
      check("id_read_last_addr", la_of(0), 32'h37);

      // Mode 0: write burst
      run_frame(0, 1'b0, 'h10, {16'h0, 16'hA3, 16'hA2, 16'hA1}, 3, 0, got);
      peek(0, 'h10, 16'hA1, "burst_a10");
      peek(0, 'h11, 16'hA2, "burst_a11");
      peek(0, 'h12, 16'hA3, "burst_a12");
      check("burst_word_count", wc_of(0), 32'd3);
      check("burst_last_addr", la_of(0), 32'h12);

      // Wrap-around write and read
      run_frame(0, 1'b0, 'h7F, {16'h0, 16'h0, 16'h22, 16'h11}, 2, 0, got);
      peek(0, 'h7F, 16'h11, "wrap_a7f");
      peek(0, 'h00, 16'h22, "wrap_a00");
      run_frame(0, 1'b1, 'h7F, '0, 2, 0, got);
      check("wrap_read_w0", 32'(got[0]), 32'h11);
      check("wrap_read_w1", 32'(got[1]), 32'h22);

      // Abort after a partial word, then recovery
      run_frame(0, 1'b0, 'h20, '0, 0, 4, got);
      peek(0, 'h20, 16'h00, "abort_a20");
      run_frame(0, 1'b0, 'h20, {16'h0, 16'h0, 16'h0, 16'h5A}, 1, 0, got);
      peek(0, 'h20, 16'h5A, "after_abort_a20");

      // Write to the ID register is recorded but not stored
      run_frame(0, 1'b0, 'h37, {16'h0, 16'h0, 16'h0, 16'h00}, 1, 0, got);
      peek(0, 'h37, 16'h91, "id_write_ignored_m0");

      // Mode 3: backdoor then two-word read; then write/read round trip
      poke(1, 'h05, 16'h5C);
      run_frame(1, 1'b1, 'h05, '0, 2, 0, got);
      check("m3_read_w0", 32'(got[0]), 32'h5C);
      check("m3_read_w1", 32'(got[1]), 32'h00);
      run_frame(1, 1'b0, 'h40, {16'h0, 16'h0, 16'hC3, 16'h3C}, 2, 0, got);
      run_frame(1, 1'b1, 'h40, '0, 2, 0, got);
      check("m3_rt_w0", 32'(got[0]), 32'h3C);
      check("m3_rt_w1", 32'(got[1]), 32'hC3);

      // 16-bit, no auto-increment
      run_frame(2, 1'b0, 'h3F, {16'h0, 16'h0, 16'hBEEF, 16'h1234}, 2, 0, got);
      peek(2, 'h3F, 16'hBEEF, "w16_a3f");
      check("w16_word_count", wc_of(2), 32'd2);
      run_frame(2, 1'b0, 'h2A, {16'h0, 16'h0, 16'h0, 16'h5555}, 1, 0, got);
      peek(2, 'h2A, 16'hC0DE, "w16_id_kept");
      check("w16_id_last_data", ld_of(2), 32'h5555);
      run_frame(2, 1'b1, 'h3F, '0, 2, 0, got);
      check("w16_read_w0", 32'(got[0]), 32'hBEEF);
      check("w16_read_w1", 32'(got[1]), 32'hBEEF);

      repeat (140) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
